// File: rtl/rs75_encoder.sv
// rtl/rs75_encoder.sv - systematic RS(7,5) encoder over GF(8), index-form symbol ports
// Message symbols pass through unchanged; two LFSR parity symbols follow, with out_last on the second.
module rs75_encoder #(
  parameter int SYMBOL_WIDTH = 3,
  parameter int N            = 7,
  parameter int K            = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [SYMBOL_WIDTH-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [SYMBOL_WIDTH-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  typedef logic [SYMBOL_WIDTH-1:0] sym_t;
  typedef enum logic {ST_MSG, ST_PARITY} state_t;

  localparam int   CW       = $clog2(K);
  localparam sym_t ALPHA3_P = sym_t'(3'b011);
  localparam sym_t ALPHA4_P = sym_t'(3'b110);

  // Multiply a polynomial-form element by alpha, reducing with x^3 = x + 1.
  function automatic sym_t mul_alpha(input sym_t a);
    return {a[SYMBOL_WIDTH-2:0], 1'b0} ^ (a[SYMBOL_WIDTH-1] ? sym_t'(3'b011) : sym_t'(3'b000));
  endfunction

  function automatic sym_t gf_mul(input sym_t a, input sym_t b);
    sym_t p;
    sym_t x;
    p = '0;
    x = a;
    for (int i = 0; i < SYMBOL_WIDTH; i++) begin
      if (b[i]) p = p ^ x;
      x = mul_alpha(x);
    end
    return p;
  endfunction

  function automatic sym_t idx_to_poly(input sym_t idx);
    case (idx)
      3'd1:    return sym_t'(3'b001);
      3'd2:    return sym_t'(3'b010);
      3'd3:    return sym_t'(3'b100);
      3'd4:    return sym_t'(3'b011);
      3'd5:    return sym_t'(3'b110);
      3'd6:    return sym_t'(3'b111);
      3'd7:    return sym_t'(3'b101);
      default: return '0;
    endcase
  endfunction

  function automatic sym_t poly_to_idx(input sym_t p);
    sym_t a;
    sym_t r;
    a = sym_t'(1);
    r = '0;
    for (int k = 0; k < N; k++) begin
      if (p == a) r = sym_t'(k + 1);
      a = mul_alpha(a);
    end
    return r;
  endfunction

  state_t          state_q, state_d;
  logic [CW-1:0]   msg_cnt_q, msg_cnt_d;
  logic            par_cnt_q, par_cnt_d;
  sym_t            r1_q, r1_d, r0_q, r0_d;
  sym_t            out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic            out_last_q, out_last_d;
  logic            slot_free;
  sym_t            fb;

  assign slot_free = !out_valid_q || out_ready;
  assign fb        = idx_to_poly(in_data) ^ r1_q;
  assign in_ready  = !reset && (state_q == ST_MSG) && slot_free;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

  always_comb begin
    state_d     = state_q;
    msg_cnt_d   = msg_cnt_q;
    par_cnt_d   = par_cnt_q;
    r1_d        = r1_q;
    r0_d        = r0_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    // Everything advances only when the output slot can take a new symbol.
    if (slot_free) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      case (state_q)
        ST_MSG: begin
          if (in_valid && in_ready) begin
            out_data_d  = in_data;
            out_valid_d = 1'b1;
            r1_d        = r0_q ^ gf_mul(fb, ALPHA4_P);
            r0_d        = gf_mul(fb, ALPHA3_P);
            if (msg_cnt_q == CW'(K - 1)) begin
              msg_cnt_d = '0;
              state_d   = ST_PARITY;
            end else begin
              msg_cnt_d = msg_cnt_q + 1'b1;
            end
          end
        end
        ST_PARITY: begin
          out_valid_d = 1'b1;
          if (!par_cnt_q) begin
            out_data_d = poly_to_idx(r1_q);
            par_cnt_d  = 1'b1;
          end else begin
            out_data_d = poly_to_idx(r0_q);
            out_last_d = 1'b1;
            par_cnt_d  = 1'b0;
            r1_d       = '0;
            r0_d       = '0;
            state_d    = ST_MSG;
          end
        end
        default: state_d = ST_MSG;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_MSG;
      msg_cnt_q   <= '0;
      par_cnt_q   <= 1'b0;
      r1_q        <= '0;
      r0_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      msg_cnt_q   <= msg_cnt_d;
      par_cnt_q   <= par_cnt_d;
      r1_q        <= r1_d;
      r0_q        <= r0_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule

// File: tb/tb_rs75_encoder.sv
// tb/tb_rs75_encoder.sv - randomized self-checking bench for rs75_encoder
// Expected codewords come from GF(8) polynomial long division by g(x); received words are also syndrome-checked.
module tb_rs75_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] in_data = 3'd0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [2:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       out_last;

  rs75_encoder #(.SYMBOL_WIDTH(3), .N(7), .K(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // GF(8) reference arithmetic in polynomial form via log/antilog tables.
  int alog[7] = '{1, 2, 4, 3, 6, 7, 5};

  function automatic int gf_log(input int p);
    for (int k = 0; k < 7; k++) if (alog[k] == p) return k;
    return 0;
  endfunction

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return alog[(gf_log(a) + gf_log(b)) % 7];
  endfunction

  function automatic int to_poly(input int idx);
    return (idx == 0) ? 0 : alog[idx - 1];
  endfunction

  function automatic int to_idx(input int p);
    return (p == 0) ? 0 : gf_log(p) + 1;
  endfunction

  int exp_data_q[$];
  bit exp_last_q[$];

  // Codeword = m(x)*x^2 + (m(x)*x^2 mod g(x)), g(x) = x^2 + a^4 x + a^3.
  task automatic push_expected(input int m[5], input int nsym);
    int a[7];
    int g1;
    int g0;
    int coef;
    g1 = to_poly(5);
    g0 = to_poly(4);
    for (int k = 0; k < 5; k++) a[6 - k] = to_poly(m[k]);
    a[1] = 0;
    a[0] = 0;
    for (int i = 6; i >= 2; i--) begin
      coef = a[i];
      a[i - 1] = a[i - 1] ^ gmul(coef, g1);
      a[i - 2] = a[i - 2] ^ gmul(coef, g0);
    end
    for (int k = 0; k < nsym; k++) begin
      exp_data_q.push_back((k < 5) ? m[k] : to_idx(a[6 - k]));
      exp_last_q.push_back(k == 6);
    end
  endtask

  logic [2:0] prev_data = 3'd0;
  logic       prev_valid = 1'b0;
  logic       prev_last = 1'b0;
  logic       prev_ready = 1'b1;
  logic       prev_reset = 1'b1;
  int         rx[$];
  int         run_len = 0;
  int         last_run = 0;
  int         acc_cnt = 0;
  int         irdy_low = 0;
  bit         win = 1'b0;
  bit         rand_ready = 1'b0;

  always @(negedge clk) begin
    int exp_d;
    bit exp_l;
    int s;
    if (!reset && !prev_reset && prev_valid && !prev_ready) begin
      check_eq("hold_data", out_data, prev_data);
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_last", out_last, prev_last);
    end
    if (reset) begin
      rx.delete();
      run_len = 0;
    end else begin
      if (out_valid) run_len++;
      else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
      if (out_valid && out_ready) begin
        check_eq("out_expected", exp_data_q.size() > 0, 1);
        if (exp_data_q.size() > 0) begin
          exp_d = exp_data_q.pop_front();
          exp_l = exp_last_q.pop_front();
          check_eq("out_data", out_data, exp_d);
          check_eq("out_last", out_last, exp_l);
        end
        rx.push_back(int'(out_data));
        if (out_last) begin
          if (rx.size() == 7) begin
            for (int j = 1; j <= 2; j++) begin
              s = 0;
              for (int k = 0; k < 7; k++) s = s ^ gmul(to_poly(rx[k]), alog[(j * (6 - k)) % 7]);
              check_eq(j == 1 ? "syndrome_a1" : "syndrome_a2", s, 0);
            end
          end
          rx.delete();
        end
      end
      if (win && in_valid && in_ready) acc_cnt++;
      if (win && acc_cnt >= 1 && acc_cnt <= 9 && !in_ready) irdy_low++;
    end
    prev_data  = out_data;
    prev_valid = out_valid;
    prev_last  = out_last;
    prev_ready = out_ready;
    prev_reset = reset;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(1, 0)) : 1'b1;
    end
  end

  task automatic wait_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input int d, input int gap_max);
    int g;
    int t;
    if (gap_max > 0) begin
      g = $urandom_range(gap_max, 0);
      if (g > 0) begin
        in_valid = 1'b0;
        repeat (g) wait_cycle();
      end
    end
    in_valid = 1'b1;
    in_data  = 3'(d);
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("accept", in_ready, 1);
    wait_cycle();
  endtask

  task automatic send_msg(input int m[5], input int nsend, input int gap_max);
    push_expected(m, (nsend == 5) ? 7 : nsend);
    for (int i = 0; i < nsend; i++) send_sym(m[i], gap_max);
  endtask

  task automatic drain();
    int t;
    in_valid = 1'b0;
    t = 0;
    while (exp_data_q.size() > 0 && t < 2000) begin
      wait_cycle();
      t++;
    end
    check_eq("drain", exp_data_q.size(), 0);
    repeat (3) wait_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int msg[5];
    int msg2[5];

    reset = 1'b1;
    repeat (3) wait_cycle();
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_in_ready", in_ready, 0);
    wait_cycle();
    reset = 1'b0;
    wait_cycle();

    msg = '{0, 0, 0, 0, 0};
    send_msg(msg, 5, 0);
    drain();
    check_eq("zero_run_len", last_run, 7);

    msg = '{1, 0, 0, 0, 0};
    send_msg(msg, 5, 0);
    drain();

    msg = '{0, 0, 0, 0, 1};
    send_msg(msg, 5, 0);
    drain();

    win = 1'b1;
    acc_cnt = 0;
    irdy_low = 0;
    msg  = '{1, 0, 0, 0, 0};
    msg2 = '{0, 0, 0, 0, 1};
    send_msg(msg, 5, 0);
    send_msg(msg2, 5, 0);
    drain();
    win = 1'b0;
    check_eq("b2b_run_len", last_run, 14);
    check_eq("b2b_in_ready_low", irdy_low, 2);

    rand_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      for (int k = 0; k < 5; k++) msg[k] = $urandom_range(7, 0);
      send_msg(msg, 5, 2);
    end
    drain();
    rand_ready = 1'b0;
    wait_cycle();

    msg = '{3, 6, 2, 7, 5};
    send_msg(msg, 3, 0);
    reset = 1'b1;
    in_valid = 1'b0;
    wait_cycle();
    @(negedge clk);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_out_last", out_last, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    exp_data_q.delete();
    exp_last_q.delete();
    wait_cycle();
    reset = 1'b0;
    wait_cycle();
    msg = '{4, 1, 0, 7, 2};
    send_msg(msg, 5, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rs75_encoder.md
Name: rs75_encoder

Overview:
- Systematic RS(7,5) encoder over GF(8), primitive polynomial x^3+x+1, sitting directly upstream of the GF-arithmetic/decoder path.
- Accepts 5 message symbols serially and emits a 7-symbol codeword: the 5 message symbols unchanged, then 2 parity symbols.
- Generator g(x) = (x+α)(x+α²) = x² + α⁴x + α³.
- All port symbols use index (log) form: 0 = zero element; k in 1..7 = α^(k-1). Table: α^0=001, α=010, α²=100, α³=011, α⁴=110, α⁵=111, α⁶=101.

Parameters:
SYMBOL_WIDTH, 3, symbol width in bits (fixed; other values unsupported)
N, 7, codeword length / multiplicative group order
K, 5, message symbols per codeword

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_data  input  SYMBOL_WIDTH  message symbol, index form
in_valid  input  1  in_data valid
in_ready  output  1  encoder accepts in_data this cycle
out_data  output  SYMBOL_WIDTH  codeword symbol, index form
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data this cycle
out_last  output  1  high with final (7th) codeword symbol

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values: out_valid=0, out_data=0, out_last=0, in_ready=0 during reset. State=MSG, msg_cnt=0, par_cnt=0, LFSR r1=r0=0.
- Internal arithmetic is in polynomial form: add = XOR; multiply via log/antilog or constant multipliers. Convert at the ports; index 0 ↔ polynomial 000.
- Output slot is one register deep. slot_free = !out_valid || out_ready.
- State MSG:
  - in_ready = slot_free.
  - On accept (in_valid && in_ready): out_data <= in_data, out_valid <= 1, out_last <= 0.
  - LFSR update: fb = in + r1; r1 <= r0 + fb·α⁴; r0 <= fb·α³.
  - msg_cnt increments. On the 5th accept, msg_cnt <= 0 and state <= PARITY.
- State PARITY:
  - in_ready = 0.
  - When slot_free and par_cnt=0: out_data <= index(r1), out_valid <= 1, par_cnt <= 1.
  - When slot_free and par_cnt=1: out_data <= index(r0), out_last <= 1, par_cnt <= 0, r1=r0 <= 0, state <= MSG.
- When slot_free and nothing is loaded, out_valid <= 0.
- Latency: an accepted symbol appears on out_data the next cycle.
- Throughput: with out_ready held high, one codeword per 7 cycles with no bubble. in_ready is low for 2 cycles per codeword.
- Backpressure: while out_valid && !out_ready, out_data, out_valid and out_last hold stable, and no LFSR or counter change occurs.
- in_valid low mid-message: the encoder waits indefinitely; LFSR and counters hold.
- A new codeword's first symbol may be accepted in the cycle after p0 is loaded.
- Reset mid-codeword discards the partial codeword. Outputs return to reset values next cycle with no out_last.
- in_data is not checked; all 8 values are legal.

Test Plan:
- Message 0,0,0,0,0 with out_ready=1 -> output 0,0,0,0,0,0,0; out_last only on the 7th symbol; out_valid high 7 consecutive cycles.
- Message 1,0,0,0,0 -> codeword 1,0,0,0,0,5,2 (parity α⁴, α). Cross-check with a GF model: codeword evaluates to zero at α and α².
- Message 0,0,0,0,1 -> codeword 0,0,0,0,1,5,4.
- Back-to-back codewords (1,0,0,0,0 then 0,0,0,0,1) with in_valid always high -> 14 contiguous valid outputs. in_ready is low exactly during the 2 parity-load cycles. The LFSR is cleared between codewords.
- Random out_ready (≈50%) and in_valid gaps with random messages -> output sequence identical to the reference model. out_data stable whenever out_valid && !out_ready.
- Assert reset after 3 accepted symbols -> next cycle out_valid=0. A following full message encodes as if from a fresh reset, with no stale parity.
